vga_grid_reader: RTL and testbench

VGA_GRID_READER -- requirements
Module: vga_grid_reader

---
 rtl/grid_pkg.sv | 20 ++
 rtl/pixel_fifo.sv | 37 +++
 rtl/vga_grid_reader.sv | 94 +++++++++
 tb/tb_vga_grid_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// grid_pkg: shared grid geometry, pixel colors, reader states and the occupancy classifier
package grid_pkg;
   localparam int GRID_WIDTH  = 160;
   localparam int GRID_HEIGHT = 120;
   localparam int PIXEL_W     = 18;
   typedef logic [2:0] color_t;
   localparam color_t FREE     = 3'b111;
   localparam color_t OCCUPIED = 3'b000;
   localparam color_t UNKNOWN  = 3'b001;
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      color_t     color;
   } pixel_t;
   function automatic color_t classify(input logic [7:0] d, input logic [7:0] free_max,
                                       input logic [7:0] occ_min);
      return d <= free_max ? FREE : d >= occ_min ? OCCUPIED : UNKNOWN;
   endfunction
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: two-entry first-word-fall-through buffer carrying classified pixels
module pixel_fifo #(
   parameter int W = 18
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);
   logic [1:0][W-1:0] mem;
   logic              wr_ptr;
   logic              rd_ptr;
   logic              push_ok;
   logic              pop_ok;
   assign pop_ok  = pop && count != 2'd0;
   assign push_ok = push && (count != 2'd2 || pop_ok);
   assign dout    = mem[rd_ptr];
   // storage and pointers; the head slot only changes on a pop, so dout holds while stalled
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= !wr_ptr;
         end
         if (pop_ok) rd_ptr <= !rd_ptr;
         count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end
endmodule

// File: rtl/vga_grid_reader.sv
// vga_grid_reader: raster-scans the occupancy grid and streams classified pixels to the VGA writer
module vga_grid_reader
   import grid_pkg::*;
#(
   parameter logic [7:0] FREE_MAX = 8'd95,
   parameter logic [7:0] OCC_MIN  = 8'd160
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       occupancy_busy,
   output logic [7:0] x_display,
   output logic [6:0] y_display,
   input  logic [7:0] occupancy_data,
   output logic       vga_busy,
   output logic [7:0] pixel_x,
   output logic [6:0] pixel_y,
   output logic [2:0] pixel_color,
   output logic       pixel_valid,
   input  logic       pixel_ready,
   output logic       frame_done
);
   state_t     state;
   state_t     state_nxt;
   logic       issue;
   logic       pop;
   logic       in_flight;
   logic       x_last;
   logic       last_addr;
   logic [7:0] rd_x;
   logic [6:0] rd_y;
   logic [1:0] count;
   logic [2:0] pending;
   pixel_t     rd_pix;
   pixel_t     head;
   assign pop         = pixel_valid && pixel_ready;
   assign pending     = {1'b0, count} + {2'b0, in_flight} - {2'b0, pop};
   assign x_last      = x_display == 8'(GRID_WIDTH - 1);
   assign last_addr   = x_last && y_display == 7'(GRID_HEIGHT - 1);
   assign rd_pix      = '{x: rd_x, y: rd_y, color: classify(occupancy_data, FREE_MAX, OCC_MIN)};
   assign pixel_valid = count != 2'd0;
   assign pixel_x     = head.x;
   assign pixel_y     = head.y;
   assign pixel_color = head.color;
   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end
   // next state, read issue and status outputs; a read issues only when the
   // FIFO is guaranteed a free slot for its data one cycle later
   always_comb begin
      state_nxt  = state;
      issue      = 1'b0;
      vga_busy   = state != IDLE;
      frame_done = state == DONE;
      case (state)
         IDLE:  state_nxt = start ? SCAN : IDLE;
         SCAN: begin
            issue     = !occupancy_busy && pending < 3'd2;
            state_nxt = issue && last_addr ? DRAIN : SCAN;
         end
         DRAIN: state_nxt = count == 2'd0 && !in_flight ? DONE : DRAIN;
         default: state_nxt = IDLE;
      endcase
   end
   // raster address counter and the address tag of the read in flight
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         x_display <= '0;
         y_display <= '0;
         rd_x      <= '0;
         rd_y      <= '0;
         in_flight <= 1'b0;
      end else begin
         in_flight <= issue;
         if (issue) begin
            rd_x      <= x_display;
            rd_y      <= y_display;
            x_display <= x_last ? '0 : x_display + 8'd1;
            if (x_last) y_display <= last_addr ? '0 : y_display + 7'd1;
         end
      end
   end
   pixel_fifo #(.W(PIXEL_W)) u_fifo (
      .clock(clock),
      .reset(reset),
      .push (in_flight),
      .din  (rd_pix),
      .pop  (pop),
      .dout (head),
      .count(count)
   );
endmodule

// File: tb/tb_vga_grid_reader.sv
// tb_vga_grid_reader: directed scenarios against a 1-cycle-latency grid memory model
module tb_vga_grid_reader;
   logic       clock;
   logic       reset;
   logic       start;
   logic       occupancy_busy;
   logic [7:0] x_display;
   logic [6:0] y_display;
   logic [7:0] occupancy_data;
   logic       vga_busy;
   logic [7:0] pixel_x;
   logic [6:0] pixel_y;
   logic [2:0] pixel_color;
   logic       pixel_valid;
   logic       pixel_ready;
   logic       frame_done;
   logic [7:0] mem [0:19199];
   int         checks = 0;
   int         errors = 0;
   bit         mon_clr = 0;
   int         pix_cnt = 0;
   int         seq_err = 0;
   int         stab_err = 0;
   int         fd_cnt = 0;
   int         exp_x = 0;
   int         exp_y = 0;
   bit         held = 0;
   logic [7:0] hx;
   logic [6:0] hy;
   logic [2:0] hc;
   logic [2:0] first_c [4];

   vga_grid_reader dut (
      .clock(clock), .reset(reset), .start(start), .occupancy_busy(occupancy_busy),
      .x_display(x_display), .y_display(y_display), .occupancy_data(occupancy_data),
      .vga_busy(vga_busy), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color),
      .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .frame_done(frame_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [2:0] model_color(input logic [7:0] d);
      return d <= 8'd95 ? 3'b111 : d >= 8'd160 ? 3'b000 : 3'b001;
   endfunction

   // grid memory model: data for the presented address appears one cycle later
   always @(posedge clock) occupancy_data <= mem[int'(y_display) * 160 + int'(x_display)];

   // stream monitor: raster order, color, stall stability and frame_done count
   always @(negedge clock) begin
      if (mon_clr) begin
         pix_cnt <= 0; seq_err <= 0; stab_err <= 0; fd_cnt <= 0;
         exp_x <= 0; exp_y <= 0; held <= 1'b0;
      end else begin
         if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
         if (held && (pixel_valid !== 1'b1 || pixel_x !== hx || pixel_y !== hy || pixel_color !== hc))
            stab_err <= stab_err + 1;
         held <= pixel_valid === 1'b1 && pixel_ready === 1'b0;
         hx <= pixel_x;
         hy <= pixel_y;
         hc <= pixel_color;
         if (pixel_valid === 1'b1 && pixel_ready === 1'b1) begin
            if (int'(pixel_x) != exp_x || int'(pixel_y) != exp_y ||
                pixel_color !== model_color(mem[exp_y * 160 + exp_x]))
               seq_err <= seq_err + 1;
            if (pix_cnt < 4) first_c[pix_cnt] <= pixel_color;
            pix_cnt <= pix_cnt + 1;
            exp_x <= exp_x == 159 ? 0 : exp_x + 1;
            if (exp_x == 159) exp_y <= exp_y == 119 ? 0 : exp_y + 1;
         end
      end
   end

   task automatic begin_pass();
      @(posedge clock); #1;
      start = 1'b1; mon_clr = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; mon_clr = 1'b0;
   endtask

   task automatic wait_done(input bit rnd, output int n);
      n = 0;
      forever begin
         @(negedge clock);
         n++;
         if (frame_done === 1'b1 || n >= 40000) break;
         @(posedge clock); #1;
         if (rnd) pixel_ready = $urandom_range(0, 99) >= 30;
      end
   endtask

   task automatic wait_addr(input int x, input int y, output int n);
      n = 0;
      while (!(int'(x_display) == x && int'(y_display) == y) && n < 20000) begin
         @(posedge clock); #1;
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++;
      if ({vga_busy, pixel_valid, frame_done} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got=%b exp=000", {vga_busy, pixel_valid, frame_done});
      end
      checks++;
      if (x_display !== 8'd0 || y_display !== 7'd0) begin
         errors++; $display("FAIL reset_addr got=(%0d,%0d) exp=(0,0)", x_display, y_display);
      end
      checks++;
      if (pixel_x !== 8'd0 || pixel_y !== 7'd0 || pixel_color !== 3'd0) begin
         errors++; $display("FAIL reset_pixel got=(%0d,%0d,%b) exp=(0,0,000)", pixel_x, pixel_y, pixel_color);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if (vga_busy !== 1'b0 || pixel_valid !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset got busy=%b valid=%b exp=0 0", vga_busy, pixel_valid);
      end
   endtask

   task automatic test_full_zero();
      int n;
      for (int i = 0; i < 19200; i++) mem[i] = 8'd0;
      pixel_ready = 1'b1;
      @(posedge clock); #1;
      start = 1'b1; mon_clr = 1'b1;
      @(negedge clock);
      checks++;
      if (vga_busy !== 1'b0) begin
         errors++; $display("FAIL busy_in_start_cycle got=%b exp=0", vga_busy);
      end
      @(posedge clock); #1;
      start = 1'b0; mon_clr = 1'b0;
      @(negedge clock);
      checks++;
      if (vga_busy !== 1'b1 || pixel_valid !== 1'b0) begin
         errors++; $display("FAIL scan_entry got busy=%b valid=%b exp=1 0", vga_busy, pixel_valid);
      end
      @(negedge clock);
      checks++;
      if (pixel_valid !== 1'b0) begin
         errors++; $display("FAIL latency_early got valid=%b exp=0", pixel_valid);
      end
      @(negedge clock);
      checks++;
      if (pixel_valid !== 1'b1 || pixel_x !== 8'd0 || pixel_y !== 7'd0 || pixel_color !== 3'b111) begin
         errors++; $display("FAIL first_pixel got v=%b (%0d,%0d,%b) exp v=1 (0,0,111)", pixel_valid, pixel_x, pixel_y, pixel_color);
      end
      wait_done(1'b0, n);
      checks++;
      if (n + 3 != 19204) begin
         errors++; $display("FAIL frame_done_cycle got=%0d exp=19204", n + 3);
      end
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (pix_cnt != 19200 || seq_err != 0) begin
         errors++; $display("FAIL zero_stream got pixels=%0d seq_err=%0d exp 19200 0", pix_cnt, seq_err);
      end
      checks++;
      if (fd_cnt != 1 || vga_busy !== 1'b0) begin
         errors++; $display("FAIL zero_end got frame_done=%0d busy=%b exp 1 0", fd_cnt, vga_busy);
      end
   endtask

   task automatic test_colors_random_ready();
      int n;
      for (int i = 0; i < 19200; i++) mem[i] = 8'((i * 37 + 11) & 255);
      mem[0] = 8'd95; mem[1] = 8'd96; mem[2] = 8'd159; mem[3] = 8'd160;
      begin_pass();
      wait_done(1'b1, n);
      @(posedge clock); #1;
      pixel_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (n >= 40000) begin
         errors++; $display("FAIL random_timeout got cycles=%0d exp <40000", n);
      end
      checks++;
      if (first_c[0] !== 3'b111 || first_c[1] !== 3'b001 || first_c[2] !== 3'b001 || first_c[3] !== 3'b000) begin
         errors++; $display("FAIL thresholds got=%b %b %b %b exp=111 001 001 000", first_c[0], first_c[1], first_c[2], first_c[3]);
      end
      checks++;
      if (pix_cnt != 19200 || seq_err != 0) begin
         errors++; $display("FAIL random_stream got pixels=%0d seq_err=%0d exp 19200 0", pix_cnt, seq_err);
      end
      checks++;
      if (stab_err != 0) begin
         errors++; $display("FAIL stall_stability got=%0d exp=0", stab_err);
      end
      checks++;
      if (fd_cnt != 1) begin
         errors++; $display("FAIL random_frame_done got=%0d exp=1", fd_cnt);
      end
   endtask

   task automatic test_busy_and_restart();
      int n;
      int bad;
      pixel_ready = 1'b1;
      begin_pass();
      wait_addr(50, 7, n);
      checks++;
      if (n >= 20000) begin
         errors++; $display("FAIL busy_reach got cycles=%0d exp <20000", n);
      end
      occupancy_busy = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (x_display !== 8'd50 || y_display !== 7'd7) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL busy_hold got moved_cycles=%0d exp=0", bad);
      end
      checks++;
      if (pixel_valid !== 1'b0) begin
         errors++; $display("FAIL busy_no_read got valid=%b exp=0", pixel_valid);
      end
      @(posedge clock); #1;
      occupancy_busy = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (x_display !== 8'd51 || y_display !== 7'd7) begin
         errors++; $display("FAIL busy_resume got=(%0d,%0d) exp=(51,7)", x_display, y_display);
      end
      repeat (100) @(posedge clock);
      #1;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      checks++;
      if (vga_busy !== 1'b1 || x_display === 8'd0) begin
         errors++; $display("FAIL start_ignored got busy=%b x=%0d exp busy=1 x!=0", vga_busy, x_display);
      end
      wait_done(1'b0, n);
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (pix_cnt != 19200 || seq_err != 0) begin
         errors++; $display("FAIL busy_stream got pixels=%0d seq_err=%0d exp 19200 0", pix_cnt, seq_err);
      end
      checks++;
      if (fd_cnt != 1) begin
         errors++; $display("FAIL busy_frame_done got=%0d exp=1", fd_cnt);
      end
   endtask

   task automatic test_reset_mid_pass();
      int n;
      pixel_ready = 1'b1;
      begin_pass();
      wait_addr(80, 60, n);
      checks++;
      if (n >= 20000 || vga_busy !== 1'b1) begin
         errors++; $display("FAIL mid_reach got cycles=%0d busy=%b exp <20000 1", n, vga_busy);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({vga_busy, pixel_valid, frame_done} !== 3'b000 || x_display !== 8'd0 || y_display !== 7'd0) begin
         errors++; $display("FAIL mid_reset_ctrl got flags=%b addr=(%0d,%0d) exp 000 (0,0)", {vga_busy, pixel_valid, frame_done}, x_display, y_display);
      end
      checks++;
      if (pixel_x !== 8'd0 || pixel_y !== 7'd0 || pixel_color !== 3'd0) begin
         errors++; $display("FAIL mid_reset_pixel got=(%0d,%0d,%b) exp=(0,0,000)", pixel_x, pixel_y, pixel_color);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if (pixel_valid !== 1'b0 || vga_busy !== 1'b0) begin
         errors++; $display("FAIL mid_reset_flush got valid=%b busy=%b exp 0 0", pixel_valid, vga_busy);
      end
      begin_pass();
      repeat (20) @(negedge clock);
      @(posedge clock); #1;
      checks++;
      if (pix_cnt != 18 || seq_err != 0) begin
         errors++; $display("FAIL restart_origin got pixels=%0d seq_err=%0d exp 18 0", pix_cnt, seq_err);
      end
      reset = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
   endtask

   // scenario sequence
   initial begin
      reset = 1'b0;
      start = 1'b0;
      occupancy_busy = 1'b0;
      pixel_ready = 1'b1;
      for (int i = 0; i < 19200; i++) mem[i] = 8'd0;
      test_reset();
      test_full_zero();
      test_colors_random_ready();
      test_busy_and_restart();
      test_reset_mid_pass();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
